// File: rtl/mil1553_gen_pkg.sv
// Shared types and constants for the MIL-STD-1553 word generator.
package mil1553_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_GAP    = 3'd4
    } gen_state_e;

    localparam int SYNC_BITS = 3;
    localparam int DATA_BITS = 16;
    localparam int WORD_BITS = 20;

    localparam int TUSER_SYNC = 0;
    localparam int TUSER_PERR = 1;
    localparam int TUSER_MERR = 2;

    // 1553 words carry odd parity over the 16 data bits.
    function automatic logic odd_parity(input logic [DATA_BITS-1:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/mil1553_gen_fifo.sv
// Synchronous FIFO with extra-MSB pointers; the head word is presented
// straight from the storage registers so a pop consumes it on the same edge.
module mil1553_gen_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(32'd1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mil1553_gen_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign rd_data   = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/mil1553_word_gen.sv
// MIL-STD-1553 Manchester II word generator with stream input and FIFO.
// Optional error injection is enabled by defining MIL1553_GEN_ERR_INJECT_EN.
module mil1553_word_gen
    import mil1553_gen_pkg::*;
#(
    parameter int CLOCK_SPEED = 50000000,
    parameter int BIT_RATE    = 1000000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        aclk,
    input  logic        arstn,
    input  logic [15:0] s_axis_tdata,
    input  logic [2:0]  s_axis_tuser,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [7:0]  gap_bits,
    output logic        tx0_1553,
    output logic        tx1_1553,
    output logic        en_tx_1553,
    output logic        busy,
    output logic        word_done
);

    localparam int HALF = CLOCK_SPEED / (2 * BIT_RATE);
    localparam int HCW  = (HALF < 2) ? 1 : $clog2(HALF);
    localparam logic [HCW-1:0] HALF_LAST = HCW'(HALF - 1);
    localparam logic [HCW-1:0] HC_ONE    = HCW'(32'd1);
    localparam logic [7:0]     SYNC_LAST = 8'(SYNC_BITS - 1);
    localparam logic [7:0]     DATA_LAST = 8'(DATA_BITS - 1);

    if (HALF < 2 || (CLOCK_SPEED % (2 * BIT_RATE)) != 0) begin : g_bad_rate
        $error("mil1553_word_gen: CLOCK_SPEED/(2*BIT_RATE) must be an integer >= 2");
    end

`ifdef MIL1553_GEN_ERR_INJECT_EN
    localparam int FW = DATA_BITS + 3;
`else
    localparam int FW = DATA_BITS + 1;
`endif

    logic [FW-1:0]        fifo_wr_s;
    logic [FW-1:0]        fifo_rd_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 push_s;
    logic                 take_s;
    logic [DATA_BITS-1:0] head_data_s;
    logic                 head_cmd_s;
    logic                 head_perr_s;
    logic                 head_merr_s;

`ifdef MIL1553_GEN_ERR_INJECT_EN
    assign fifo_wr_s   = {s_axis_tuser[TUSER_MERR], s_axis_tuser[TUSER_PERR],
                          s_axis_tuser[TUSER_SYNC], s_axis_tdata};
    assign head_perr_s = fifo_rd_s[DATA_BITS+1];
    assign head_merr_s = fifo_rd_s[DATA_BITS+2];
`else
    logic unused_tuser_s;
    assign unused_tuser_s = ^s_axis_tuser[2:1];
    assign fifo_wr_s   = {s_axis_tuser[TUSER_SYNC], s_axis_tdata};
    assign head_perr_s = 1'b0;
    assign head_merr_s = 1'b0;
`endif

    assign head_data_s = fifo_rd_s[DATA_BITS-1:0];
    assign head_cmd_s  = fifo_rd_s[DATA_BITS];

    logic ready_r;
    assign s_axis_tready = ready_r && !fifo_full_s;
    assign push_s        = s_axis_tvalid && s_axis_tready;

    mil1553_gen_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (aclk),
        .rst_n   (arstn),
        .push    (push_s),
        .wr_data (fifo_wr_s),
        .pop     (take_s),
        .rd_data (fifo_rd_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    gen_state_e           state_r,    state_n;
    logic [HCW-1:0]       half_cnt_r, half_cnt_n;
    logic                 h_r,        h_n;
    logic [7:0]           bit_cnt_r,  bit_cnt_n;
    logic [DATA_BITS-1:0] shift_r,    shift_n;
    logic                 cmd_r,      cmd_n;
    logic                 par_r,      par_n;
    logic                 merr_r,     merr_n;
    logic [7:0]           gap_r,      gap_n;
    logic                 half_end_s;
    logic                 bit_end_s;
    logic                 en_s;
    logic                 tx_s;
    logic                 done_s;
    logic                 sync_first_s;

    logic tx0_r, tx1_r, en_r, busy_r, done_r;

    assign half_end_s   = (half_cnt_r == HALF_LAST);
    assign bit_end_s    = half_end_s && h_r;
    assign sync_first_s = (bit_cnt_r == 8'd0) || ((bit_cnt_r == 8'd1) && !h_r);

    // Next-state, timing counters and line level for the current half-bit.
    always_comb begin
        state_n    = state_r;
        half_cnt_n = half_cnt_r;
        h_n        = h_r;
        bit_cnt_n  = bit_cnt_r;
        shift_n    = shift_r;
        cmd_n      = cmd_r;
        par_n      = par_r;
        merr_n     = merr_r;
        gap_n      = gap_r;
        take_s     = 1'b0;
        en_s       = 1'b0;
        tx_s       = 1'b0;
        done_s     = 1'b0;

        if (state_r != ST_IDLE) begin
            half_cnt_n = half_end_s ? '0 : (half_cnt_r + HC_ONE);
            h_n        = h_r ^ half_end_s;
            bit_cnt_n  = bit_end_s ? (bit_cnt_r + 8'd1) : bit_cnt_r;
        end else begin
            half_cnt_n = '0;
            h_n        = 1'b0;
            bit_cnt_n  = 8'd0;
        end

        case (state_r)
            ST_IDLE: begin
                take_s = !fifo_empty_s;
            end
            ST_SYNC: begin
                en_s = 1'b1;
                tx_s = cmd_r ? sync_first_s : !sync_first_s;
                if (bit_end_s && (bit_cnt_r == SYNC_LAST)) begin
                    state_n   = ST_DATA;
                    bit_cnt_n = 8'd0;
                end else begin
                    state_n = ST_SYNC;
                end
            end
            ST_DATA: begin
                en_s = 1'b1;
                // A corrupted final bit keeps its second-half level throughout.
                if (merr_r && (bit_cnt_r == DATA_LAST)) begin
                    tx_s = !shift_r[DATA_BITS-1];
                end else begin
                    tx_s = shift_r[DATA_BITS-1] ^ h_r;
                end
                if (bit_end_s) begin
                    shift_n = {shift_r[DATA_BITS-2:0], 1'b0};
                end else begin
                    shift_n = shift_r;
                end
                if (bit_end_s && (bit_cnt_r == DATA_LAST)) begin
                    state_n   = ST_PARITY;
                    bit_cnt_n = 8'd0;
                end else begin
                    state_n = ST_DATA;
                end
            end
            ST_PARITY: begin
                en_s = 1'b1;
                tx_s = par_r ^ h_r;
                if (bit_end_s) begin
                    done_s = 1'b1;
                    gap_n  = gap_bits;
                    if (gap_bits == 8'd0) begin
                        take_s  = !fifo_empty_s;
                        state_n = ST_IDLE;
                    end else begin
                        state_n   = ST_GAP;
                        bit_cnt_n = 8'd0;
                    end
                end else begin
                    state_n = ST_PARITY;
                end
            end
            ST_GAP: begin
                if (bit_end_s && (bit_cnt_r == (gap_r - 8'd1))) begin
                    take_s  = !fifo_empty_s;
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_GAP;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Starting a word overrides whatever the state decided above.
        if (take_s) begin
            state_n   = ST_SYNC;
            bit_cnt_n = 8'd0;
            shift_n   = head_data_s;
            cmd_n     = head_cmd_s;
            par_n     = head_perr_s ? !odd_parity(head_data_s) : odd_parity(head_data_s);
            merr_n    = head_merr_s;
        end else begin
            merr_n = merr_n;
        end
    end

    // State, datapath and registered line outputs.
    always_ff @(posedge aclk) begin
        if (!arstn) begin
            state_r    <= ST_IDLE;
            half_cnt_r <= '0;
            h_r        <= 1'b0;
            bit_cnt_r  <= 8'd0;
            shift_r    <= '0;
            cmd_r      <= 1'b0;
            par_r      <= 1'b0;
            merr_r     <= 1'b0;
            gap_r      <= 8'd0;
            ready_r    <= 1'b0;
            tx0_r      <= 1'b0;
            tx1_r      <= 1'b0;
            en_r       <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            half_cnt_r <= half_cnt_n;
            h_r        <= h_n;
            bit_cnt_r  <= bit_cnt_n;
            shift_r    <= shift_n;
            cmd_r      <= cmd_n;
            par_r      <= par_n;
            merr_r     <= merr_n;
            gap_r      <= gap_n;
            ready_r    <= 1'b1;
            tx0_r      <= en_s && tx_s;
            tx1_r      <= en_s && !tx_s;
            en_r       <= en_s;
            busy_r     <= (state_r != ST_IDLE) || !fifo_empty_s;
            done_r     <= done_s;
        end
    end

    assign tx0_1553   = tx0_r;
    assign tx1_1553   = tx1_r;
    assign en_tx_1553 = en_r;
    assign busy       = busy_r;
    assign word_done  = done_r;

endmodule
